cnn_layer_accel_weight_sequencer: RTL and testbench

Parametrised, programmable successor to the fixed weight-sequence table in the QUAD datapath. Holds four runtime-writable weight-address sequences of configurable length and depth, selects one from `gray_code` parity and `sequence_selector`, and autonomously streams its entries, optionally repeated, to the weight buffer over a valid/ready handshake. Sits between the QUAD controller, which issues start and configuration, and the weight BRAM read port, which consumes `wht_data_addr`.

---
 rtl/cnn_layer_accel_wht_seq_pkg.sv | 34 +++
 rtl/cnn_layer_accel_wht_seq_table.sv | 71 +++++++
 rtl/cnn_layer_accel_weight_sequencer.sv | 165 ++++++++++++++++
 tb/tb_cnn_layer_accel_weight_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_layer_accel_wht_seq_pkg.sv
// Shared types, default weight-sequence table and sequence-select helper.
package cnn_layer_accel_wht_seq_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam int NUM_SEQ = 4;
   localparam int DEF_LEN = 5;

   // Default entries, indexed [seq][idx]; entry 0 is the rightmost nibble.
   localparam logic [3:0][4:0][3:0] DEF_TABLE = {
      {4'd5, 4'd4, 4'd3, 4'd1, 4'd0},   // seq3
      {4'd5, 4'd4, 4'd3, 4'd2, 4'd0},   // seq2
      {4'd8, 4'd7, 4'd6, 4'd1, 4'd0},   // seq1
      {4'd8, 4'd7, 4'd6, 4'd2, 4'd0}    // seq0
   };

   // Reset value of one table entry; entries past the default length are zero.
   function automatic logic [3:0] def_entry_f(input logic [1:0] seq, input int idx);
      logic [2:0] idx_s;
      idx_s = idx[2:0];
      if (idx < DEF_LEN) return DEF_TABLE[seq][idx_s];
      return 4'd0;
   endfunction

   // Sequence id from gray-code parity and selector; shared with the controller model.
   function automatic logic [1:0] seq_id_f(input logic [1:0] gray_code,
                                           input logic       sequence_selector);
      return {gray_code[1] ^ gray_code[0], ~sequence_selector};
   endfunction

endpackage

// File: rtl/cnn_layer_accel_wht_seq_table.sv
// Four runtime-writable weight-address sequences with per-sequence lengths.
module cnn_layer_accel_wht_seq_table
   import cnn_layer_accel_wht_seq_pkg::*;
#(
   parameter int SEQ_DEPTH      = 8,
   parameter int WHT_ADDR_WIDTH = 4,
   parameter int IDX_W          = $clog2(SEQ_DEPTH),
   parameter int LEN_W          = $clog2(SEQ_DEPTH + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic                      len_wr_en,
   input  logic [1:0]                wr_seq,
   input  logic [IDX_W-1:0]          wr_idx,
   input  logic [WHT_ADDR_WIDTH-1:0] wr_data,
   input  logic [LEN_W-1:0]          wr_len,
   input  logic [1:0]                rd_seq,
   input  logic [IDX_W-1:0]          rd_idx,
   output logic [WHT_ADDR_WIDTH-1:0] rd_data,
   output logic [LEN_W-1:0]          rd_len
);

   logic [WHT_ADDR_WIDTH-1:0] mem_q [NUM_SEQ][SEQ_DEPTH];
   logic [WHT_ADDR_WIDTH-1:0] mem_d [NUM_SEQ][SEQ_DEPTH];
   logic [LEN_W-1:0]          len_q [NUM_SEQ];
   logic [LEN_W-1:0]          len_d [NUM_SEQ];
   logic [LEN_W-1:0]          len_clamped;

   // Length 0 means a single entry; anything beyond the table depth saturates.
   always_comb begin
      len_clamped = wr_len;
      if (wr_len == '0)
         len_clamped = LEN_W'(1);
      else if (wr_len > LEN_W'(SEQ_DEPTH))
         len_clamped = LEN_W'(SEQ_DEPTH);
   end

   // Next table state: apply the (already IDLE-gated) write ports.
   always_comb begin
      mem_d = mem_q;
      len_d = len_q;
      if (wr_en && (int'(wr_idx) < SEQ_DEPTH))
         mem_d[wr_seq][wr_idx] = wr_data;
      if (len_wr_en)
         len_d[wr_seq] = len_clamped;
   end

   // Table registers with their power-on defaults.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < NUM_SEQ; s++) begin
            len_q[s] <= LEN_W'(DEF_LEN);
            for (int i = 0; i < SEQ_DEPTH; i++)
               mem_q[s][i] <= WHT_ADDR_WIDTH'(def_entry_f(2'(s), i));
         end
      end else begin
         mem_q <= mem_d;
         len_q <= len_d;
      end
   end

   // Combinational read port; out-of-range indices read as zero.
   always_comb begin
      rd_data = '0;
      if (int'(rd_idx) < SEQ_DEPTH)
         rd_data = mem_q[rd_seq][rd_idx];
      rd_len = len_q[rd_seq];
   end

endmodule

// File: rtl/cnn_layer_accel_weight_sequencer.sv
// Streams a selected, optionally repeated weight-address sequence over valid/ready.
module cnn_layer_accel_weight_sequencer
   import cnn_layer_accel_wht_seq_pkg::*;
#(
   parameter  int SEQ_DEPTH      = 8,
   parameter  int WHT_ADDR_WIDTH = 4,
   parameter  int REPEAT_WIDTH   = 8,
   localparam int IDX_W          = $clog2(SEQ_DEPTH),
   localparam int LEN_W          = $clog2(SEQ_DEPTH + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cfg_wr_en,
   input  logic                      cfg_len_wr_en,
   input  logic [1:0]                cfg_seq_id,
   input  logic [IDX_W-1:0]          cfg_idx,
   input  logic [WHT_ADDR_WIDTH-1:0] cfg_data,
   input  logic [LEN_W-1:0]          cfg_len,
   input  logic                      start,
   input  logic                      abort,
   input  logic [1:0]                gray_code,
   input  logic                      sequence_selector,
   input  logic [REPEAT_WIDTH-1:0]   repeat_count,
   output logic [WHT_ADDR_WIDTH-1:0] wht_data_addr,
   output logic                      wht_data_valid,
   input  logic                      wht_data_ready,
   output logic                      wht_data_last,
   output logic                      busy,
   output logic                      done
);

   if (SEQ_DEPTH < 5) begin : g_depth_chk
      $error("SEQ_DEPTH must be at least 5");
   end
   if (WHT_ADDR_WIDTH < 4) begin : g_width_chk
      $error("WHT_ADDR_WIDTH must be at least 4");
   end

   state_e                    state_q, state_d;
   logic [1:0]                seq_q, seq_d;
   logic [LEN_W-1:0]          len_q, len_d;
   logic [REPEAT_WIDTH-1:0]   rep_q, rep_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [REPEAT_WIDTH-1:0]   pass_q, pass_d;
   logic [WHT_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                      valid_q, valid_d;
   logic                      done_q, done_d;

   logic                      cfg_any, start_ok, hs, at_end_idx, at_end_pass;
   logic [1:0]                rd_seq;
   logic [IDX_W-1:0]          rd_idx;
   logic [WHT_ADDR_WIDTH-1:0] rd_data;
   logic [LEN_W-1:0]          rd_len;

   // Configuration is only honoured while idle so a running stream never changes.
   cnn_layer_accel_wht_seq_table #(
      .SEQ_DEPTH      (SEQ_DEPTH),
      .WHT_ADDR_WIDTH (WHT_ADDR_WIDTH),
      .IDX_W          (IDX_W),
      .LEN_W          (LEN_W)
   ) u_table (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (cfg_wr_en && (state_q == ST_IDLE)),
      .len_wr_en (cfg_len_wr_en && (state_q == ST_IDLE)),
      .wr_seq    (cfg_seq_id),
      .wr_idx    (cfg_idx),
      .wr_data   (cfg_data),
      .wr_len    (cfg_len),
      .rd_seq    (rd_seq),
      .rd_idx    (rd_idx),
      .rd_data   (rd_data),
      .rd_len    (rd_len)
   );

   // Event decode and table read pointer for the entry to be loaded next.
   always_comb begin
      cfg_any     = cfg_wr_en || cfg_len_wr_en;
      start_ok    = (state_q == ST_IDLE) && start && !cfg_any;
      hs          = (state_q == ST_RUN) && !abort && valid_q && wht_data_ready;
      at_end_idx  = (LEN_W'(idx_q) == (len_q - LEN_W'(1)));
      at_end_pass = (pass_q == (rep_q - REPEAT_WIDTH'(1)));
      rd_seq      = start_ok ? seq_id_f(gray_code, sequence_selector) : seq_q;
      rd_idx      = (start_ok || at_end_idx) ? '0 : (idx_q + IDX_W'(1));
   end

   // FSM next state, counters and output register contents.
   always_comb begin
      state_d = state_q;
      seq_d   = seq_q;
      len_d   = len_q;
      rep_d   = rep_q;
      idx_d   = idx_q;
      pass_d  = pass_q;
      addr_d  = addr_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               state_d = ST_RUN;
               seq_d   = rd_seq;
               len_d   = rd_len;
               rep_d   = (repeat_count == '0) ? REPEAT_WIDTH'(1) : repeat_count;
               idx_d   = '0;
               pass_d  = '0;
               addr_d  = rd_data;
               valid_d = 1'b1;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
            end else if (hs) begin
               if (!at_end_idx) begin
                  idx_d  = rd_idx;
                  addr_d = rd_data;
               end else if (!at_end_pass) begin
                  idx_d  = '0;
                  pass_d = pass_q + REPEAT_WIDTH'(1);
                  addr_d = rd_data;
               end else begin
                  state_d = ST_IDLE;
                  valid_d = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         seq_q   <= '0;
         len_q   <= LEN_W'(1);
         rep_q   <= REPEAT_WIDTH'(1);
         idx_q   <= '0;
         pass_q  <= '0;
         addr_q  <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         seq_q   <= seq_d;
         len_q   <= len_d;
         rep_q   <= rep_d;
         idx_q   <= idx_d;
         pass_q  <= pass_d;
         addr_q  <= addr_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   assign wht_data_addr  = addr_q;
   assign wht_data_valid = valid_q;
   assign wht_data_last  = valid_q && at_end_idx && at_end_pass;
   assign busy           = (state_q == ST_RUN);
   assign done           = done_q;

endmodule

// File: tb/tb_cnn_layer_accel_weight_sequencer.sv
// Scoreboard bench for the weight sequencer.
module tb_cnn_layer_accel_weight_sequencer;

   localparam int SEQ_DEPTH = 8;
   localparam int WA        = 4;
   localparam int RW        = 8;
   localparam int IDX_W     = 3;
   localparam int LEN_W     = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             cfg_wr_en, cfg_len_wr_en;
   logic [1:0]       cfg_seq_id;
   logic [IDX_W-1:0] cfg_idx;
   logic [WA-1:0]    cfg_data;
   logic [LEN_W-1:0] cfg_len;
   logic             start, abort;
   logic [1:0]       gray_code;
   logic             sequence_selector;
   logic [RW-1:0]    repeat_count;
   logic [WA-1:0]    wht_data_addr;
   logic             wht_data_valid, wht_data_ready, wht_data_last;
   logic             busy, done;

   int checks = 0;
   int errors = 0;

   logic [WA:0]   exp_q[$];            // {last, addr}
   logic [WA-1:0] m_tbl [4][SEQ_DEPTH];
   int            m_len [4];

   cnn_layer_accel_weight_sequencer #(
      .SEQ_DEPTH(SEQ_DEPTH), .WHT_ADDR_WIDTH(WA), .REPEAT_WIDTH(RW)
   ) dut (
      .clk(clk), .rst(rst),
      .cfg_wr_en(cfg_wr_en), .cfg_len_wr_en(cfg_len_wr_en),
      .cfg_seq_id(cfg_seq_id), .cfg_idx(cfg_idx), .cfg_data(cfg_data), .cfg_len(cfg_len),
      .start(start), .abort(abort), .gray_code(gray_code),
      .sequence_selector(sequence_selector), .repeat_count(repeat_count),
      .wht_data_addr(wht_data_addr), .wht_data_valid(wht_data_valid),
      .wht_data_ready(wht_data_ready), .wht_data_last(wht_data_last),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic model_reset();
      int defs [4][5] = '{'{0,2,6,7,8}, '{0,1,6,7,8}, '{0,2,3,4,5}, '{0,1,3,4,5}};
      for (int s = 0; s < 4; s++) begin
         m_len[s] = 5;
         for (int i = 0; i < SEQ_DEPTH; i++)
            m_tbl[s][i] = (i < 5) ? WA'(defs[s][i]) : '0;
      end
   endtask

   task automatic cfg_write(input int seq, input int idx, input int data);
      cfg_seq_id = 2'(seq); cfg_idx = IDX_W'(idx); cfg_data = WA'(data);
      cfg_wr_en  = 1'b1;
      tick();
      cfg_wr_en  = 1'b0;
      m_tbl[seq][idx] = WA'(data);
   endtask

   task automatic cfg_length(input int seq, input int len);
      cfg_seq_id = 2'(seq); cfg_len = LEN_W'(len);
      cfg_len_wr_en = 1'b1;
      tick();
      cfg_len_wr_en = 1'b0;
      m_len[seq] = (len == 0) ? 1 : ((len > SEQ_DEPTH) ? SEQ_DEPTH : len);
   endtask

   // Pushes the expected beats and issues start; called at a negedge.
   task automatic launch(input logic [1:0] g, input logic sel, input int rep);
      int s, r, l;
      logic par;
      par = g[1] ^ g[0];
      if (!par && sel)       s = 0;
      else if (!par && !sel) s = 1;
      else if (par && sel)   s = 2;
      else                   s = 3;
      r = (rep == 0) ? 1 : rep;
      l = m_len[s];
      for (int p = 0; p < r; p++)
         for (int i = 0; i < l; i++)
            exp_q.push_back({(i == l - 1) && (p == r - 1), m_tbl[s][i]});
      gray_code = g; sequence_selector = sel; repeat_count = RW'(rep);
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (wht_data_valid !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL launch_latency valid=%0b busy=%0b required 1 1", wht_data_valid, busy);
      end
   endtask

   // Drains the scoreboard; mode 0 keeps ready high, mode 1 stalls randomly.
   task automatic consume(input int mode);
      int          cyc = 0;
      int          stall_cnt = 0;
      bit          finished = 0;
      bit          prev_stall = 0;
      logic [WA:0] prev = '0;
      logic [WA:0] e;
      while (!finished && cyc < 400) begin
         if (mode == 0)
            wht_data_ready = 1'b1;
         else if (wht_data_valid && wht_data_addr == 4'd6 && stall_cnt < 3) begin
            wht_data_ready = 1'b0;
            stall_cnt++;
         end else
            wht_data_ready = 1'($urandom_range(0, 1));
         checks++;
         if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_early done=%0b required 0", done);
         end
         if (prev_stall) begin
            checks++;
            if ({wht_data_last, wht_data_addr} !== prev || wht_data_valid !== 1'b1) begin
               errors++;
               $display("FAIL stall_hold addr=%0d last=%0b valid=%0b required addr=%0d last=%0b valid=1",
                        wht_data_addr, wht_data_last, wht_data_valid, prev[WA-1:0], prev[WA]);
            end
         end
         if (mode == 0) begin
            checks++;
            if (wht_data_valid !== 1'b1) begin
               errors++;
               $display("FAIL stream_gap valid=%0b required 1", wht_data_valid);
            end
         end
         if (wht_data_valid === 1'b1 && wht_data_ready) begin
            e = exp_q.pop_front();
            checks++;
            if ({wht_data_last, wht_data_addr} !== e) begin
               errors++;
               $display("FAIL beat addr=%0d last=%0b required addr=%0d last=%0b",
                        wht_data_addr, wht_data_last, e[WA-1:0], e[WA]);
            end else
               $display("beat addr=%0d last=%0b", wht_data_addr, wht_data_last);
            if (exp_q.size() == 0) finished = 1;
         end
         prev_stall = (wht_data_valid === 1'b1) && !wht_data_ready;
         prev       = {wht_data_last, wht_data_addr};
         tick();
         cyc++;
      end
      wht_data_ready = 1'b1;
      checks++;
      if (!finished) begin
         errors++;
         $display("FAIL stream_timeout beats_left=%0d required 0", exp_q.size());
         exp_q.delete();
      end else if (done !== 1'b1 || wht_data_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL completion done=%0b valid=%0b busy=%0b required 1 0 0",
                  done, wht_data_valid, busy);
      end
   endtask

   task automatic stream(input logic [1:0] g, input logic sel, input int rep, input int mode);
      launch(g, sel, rep);
      consume(mode);
   endtask

   task automatic check_idle_outputs(input string name);
      checks++;
      if (wht_data_valid !== 1'b0 || wht_data_addr !== '0 || wht_data_last !== 1'b0 ||
          busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL %s valid=%0b addr=%0d last=%0b busy=%0b done=%0b required all 0",
                  name, wht_data_valid, wht_data_addr, wht_data_last, busy, done);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cfg_wr_en = 0; cfg_len_wr_en = 0; cfg_seq_id = 0; cfg_idx = 0; cfg_data = 0; cfg_len = 0;
      start = 0; abort = 0; gray_code = 0; sequence_selector = 0; repeat_count = 0;
      wht_data_ready = 1'b1;
      model_reset();
      #1;
      check_idle_outputs("reset_async");
      tick(); tick();
      check_idle_outputs("reset_held");
      rst = 1'b0;
      tick();
      check_idle_outputs("reset_release");
   endtask

   task automatic test_basic();
      stream(2'b00, 1'b1, 1, 0);
   endtask

   task automatic test_repeat();
      stream(2'b10, 1'b0, 3, 0);
      stream(2'b11, 1'b1, 0, 0);
   endtask

   task automatic test_cfg_write();
      cfg_write(2, 0, 9);
      cfg_write(2, 1, 3);
      cfg_write(2, 2, 1);
      cfg_length(2, 3);
      stream(2'b01, 1'b1, 1, 0);
      cfg_length(2, 0);
      stream(2'b01, 1'b1, 1, 0);
      cfg_length(1, 15);
      stream(2'b00, 1'b0, 1, 0);
   endtask

   task automatic test_stall();
      stream(2'b00, 1'b1, 2, 1);
   endtask

   task automatic test_abort();
      logic [WA:0] e;
      launch(2'b00, 1'b1, 1);
      wht_data_ready = 1'b1;
      for (int b = 0; b < 2; b++) begin
         e = exp_q.pop_front();
         checks++;
         if ({wht_data_last, wht_data_addr} !== e) begin
            errors++;
            $display("FAIL abort_pre_beat addr=%0d required %0d", wht_data_addr, e[WA-1:0]);
         end
         tick();
      end
      abort = 1'b1;
      checks++;
      if (wht_data_addr !== exp_q[0][WA-1:0]) begin
         errors++;
         $display("FAIL abort_beat3 addr=%0d required %0d", wht_data_addr, exp_q[0][WA-1:0]);
      end
      tick();
      abort = 1'b0;
      checks++;
      if (wht_data_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort_stop valid=%0b busy=%0b done=%0b required 0 0 0",
                  wht_data_valid, busy, done);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL abort_no_done done=%0b required 0", done);
      end
      exp_q.delete();
      stream(2'b00, 1'b1, 1, 0);
   endtask

   task automatic test_cfg_in_run();
      launch(2'b00, 1'b1, 1);
      wht_data_ready = 1'b0;
      cfg_seq_id = 2'd0; cfg_idx = 3'd1; cfg_data = 4'd15; cfg_len = 4'd2;
      cfg_wr_en = 1'b1; cfg_len_wr_en = 1'b1;
      tick();
      cfg_wr_en = 1'b0; cfg_len_wr_en = 1'b0;
      consume(0);
      stream(2'b00, 1'b1, 1, 0);
   endtask

   task automatic test_start_with_cfg();
      gray_code = 2'b10; sequence_selector = 1'b0; repeat_count = 8'd1;
      cfg_seq_id = 2'd3; cfg_idx = 3'd7; cfg_data = 4'd3;
      cfg_wr_en = 1'b1; start = 1'b1;
      tick();
      cfg_wr_en = 1'b0; start = 1'b0;
      m_tbl[3][7] = 4'd3;
      checks++;
      if (busy !== 1'b0 || wht_data_valid !== 1'b0) begin
         errors++;
         $display("FAIL start_with_cfg busy=%0b valid=%0b required 0 0", busy, wht_data_valid);
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL start_with_cfg_late busy=%0b required 0", busy);
      end
      cfg_length(3, 8);
      stream(2'b10, 1'b0, 1, 0);
   endtask

   task automatic test_reset_mid_stream();
      logic [WA:0] e;
      cfg_write(0, 0, 11);
      launch(2'b00, 1'b1, 1);
      wht_data_ready = 1'b1;
      e = exp_q.pop_front();
      checks++;
      if ({wht_data_last, wht_data_addr} !== e) begin
         errors++;
         $display("FAIL rst_pre_beat addr=%0d required %0d", wht_data_addr, e[WA-1:0]);
      end
      tick();
      #2 rst = 1'b1;
      #1 check_idle_outputs("rst_mid_stream");
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      exp_q.delete();
      tick();
      stream(2'b00, 1'b1, 1, 0);
      stream(2'b10, 1'b0, 1, 0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_repeat();
      test_cfg_write();
      test_stall();
      test_abort();
      test_cfg_in_run();
      test_start_with_cfg();
      test_reset_mid_stream();
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
